// File: rtl/dut_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dut_pkg
//  Description : Shared constants and types for the stream FIFO block and its
//                bench: default data width and depth, the output-stage state
//                type, and the clock period / drive skew used by the bench.
//  Revision    : 1.0  initial release
// ============================================================================
package dut_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    // Bench clock period and the delay after an active edge at which inputs
    // are driven and registered outputs are sampled.
    localparam int CYCLE      = 10;
    localparam int DRIVE_SKEW = CYCLE / 10;

    // Output register state: EMPTY means dout carries no word.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        VALID = 1'b1
    } out_state_e;

endpackage : dut_pkg
`default_nettype wire

// File: rtl/dut_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : dut_fifo_mem
//  Description : ENTRIES x DATA_W register array, one synchronous write port
//                and one asynchronous read port. The storage is not reset;
//                the owner tracks which entries hold live words.
//  Ports       : clk      - clock
//                we_i     - write enable
//                waddr_i  - write address
//                wdata_i  - write data
//                raddr_i  - read address
//                rdata_o  - read data (combinational from raddr_i)
//  Revision    : 1.0  initial release
// ============================================================================
module dut_fifo_mem #(
    parameter int DATA_W  = 16,
    parameter int ENTRIES = 7,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : dut_fifo_mem
`default_nettype wire

// File: rtl/dut_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dut_stream_fifo
//  Description : First-word-fall-through stream FIFO with valid/ready on both
//                sides. Capacity is DEPTH words: DEPTH-1 in a memory plus the
//                dout register. Reports occupancy and an almost-full flag and
//                supports a synchronous flush.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                flush           - synchronous clear of all stored words
//                din/din_valid   - write side, accepted when din_ready
//                din_ready       - registered, count_next < DEPTH
//                dout/dout_valid - registered head of queue
//                dout_ready      - consumer takes dout
//                count           - words held (memory + output register)
//                almost_full     - count >= AFULL_TH
//  Revision    : 1.0  initial release
// ============================================================================
module dut_stream_fifo
    import dut_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int MEM_DEPTH = DEPTH - 1;

    localparam logic [PTR_W-1:0] C_PTR_LAST  = PTR_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_AFULL = CNT_W'(AFULL_TH);

    // Memory depth is not a power of two, so pointers wrap by compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    out_state_e        state_q,     state_d;
    logic [DATA_W-1:0] dout_q,      dout_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              din_ready_q, din_ready_d;
    logic              afull_q,     afull_d;

    logic              push;
    logic              pop;
    logic              mem_empty;
    logic              load_slot;
    logic              rd_en;
    logic              bypass;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        push      = din_valid && din_ready_q;
        pop       = (state_q == VALID) && dout_ready;
        // Words in memory = count minus the one parked in dout (if any).
        mem_empty = (state_q == VALID) ? (count_q <= C_CNT_ONE) : (count_q == '0);
        // The output register will be free after this edge.
        load_slot = (state_q == EMPTY) || pop;
        rd_en     = load_slot && !mem_empty;
        // din goes straight to dout only when nothing older is queued.
        bypass    = load_slot && mem_empty && push;
        mem_we    = push && !bypass && !flush;

        state_d     = state_q;
        dout_d      = dout_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (rd_en) begin
            dout_d   = mem_rdata;
            state_d  = VALID;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else if (bypass) begin
            dout_d   = din;
            state_d  = VALID;
        end else if (load_slot) begin
            state_d  = EMPTY;
        end

        if (mem_we) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase

        // Flush overrides any push/pop; dout keeps its stale contents.
        if (flush) begin
            state_d  = EMPTY;
            dout_d   = dout_q;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        din_ready_d = (count_d < C_CNT_FULL);
        afull_d     = (count_d >= C_CNT_AFULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            dout_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            din_ready_q <= 1'b0;
            afull_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            din_ready_q <= din_ready_d;
            afull_q     <= afull_d;
        end
    end

    dut_fifo_mem #(
        .DATA_W  (DATA_W),
        .ENTRIES (MEM_DEPTH),
        .ADDR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign din_ready   = din_ready_q;
    assign dout        = dout_q;
    assign dout_valid  = (state_q == VALID);
    assign count       = count_q;
    assign almost_full = afull_q;

endmodule : dut_stream_fifo
`default_nettype wire

// File: tb/tb_dut_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dut_stream_fifo
//  Description : Self-checking bench for dut_stream_fifo. A queue holds the
//                words the FIFO should contain; the driver appends accepted
//                words and checks status flags, a monitor pops and compares
//                every word the DUT hands out.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dut_stream_fifo;
    import dut_pkg::*;

    localparam int DW       = 16;
    localparam int DEPTH    = 8;
    localparam int AFULL_TH = 6;
    localparam int CW       = $clog2(DEPTH + 1);

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          flush      = 1'b0;
    logic [DW-1:0] din        = '0;
    logic          din_valid  = 1'b0;
    logic          dout_ready = 1'b0;
    logic          din_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [CW-1:0] count;
    logic          almost_full;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] sb[$];
    bit            m_up  = 1'b0;

    always #(CYCLE / 2) clk = ~clk;

    dut_stream_fifo #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Status expected from the reference queue (state after the last edge).
    task automatic check_state();
        int n;
        n = sb.size();
        check("din_ready",   32'(din_ready),   32'(m_up && (n < DEPTH)));
        check("count",       32'(count),       32'(n));
        check("dout_valid",  32'(dout_valid),  32'(n > 0));
        check("almost_full", 32'(almost_full), 32'(n >= AFULL_TH));
        if (n > 0) check("dout_head", 32'(dout), 32'(sb[0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_din_ready"},   32'(din_ready),   32'h0);
        check({tag, "_dout_valid"},  32'(dout_valid),  32'h0);
        check({tag, "_dout"},        32'(dout),        32'h0);
        check({tag, "_count"},       32'(count),       32'h0);
        check({tag, "_almost_full"}, 32'(almost_full), 32'h0);
    endtask

    // Called DRIVE_SKEW after a posedge: check, drive, advance one cycle.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
        bit acc;
        check_state();
        acc        = v && m_up && (sb.size() < DEPTH) && !f;
        din_valid  = v;
        din        = d;
        dout_ready = r;
        flush      = f;
        if (f)        sb.delete();
        else if (acc) sb.push_back(d);
        @(posedge clk);
        #(DRIVE_SKEW);
    endtask

    // Asserts rst between edges, holds for n edges, releases between edges.
    task automatic do_reset(input int n);
        rst        = 1'b1;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        flush      = 1'b0;
        #(DRIVE_SKEW);
        check_reset_outputs("rst_async");
        sb.delete();
        m_up = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #(DRIVE_SKEW);
            check_reset_outputs("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #(DRIVE_SKEW);
        m_up = 1'b1;
    endtask

    // Monitor: every word handed out must be the oldest expected word.
    initial begin
        logic [DW-1:0] exp_w;
        forever begin
            @(negedge clk);
            if (!rst && !flush && dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %0h expected no word", dout);
                end else begin
                    exp_w = sb.pop_front();
                    check("pop_data", 32'(dout), 32'(exp_w));
                end
            end
        end
    end

    initial begin
        #(CYCLE * 20000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset(3);

        // Fill to full with the consumer stalled, then one refused push.
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Drain in order.
        repeat (9) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Streaming: simultaneous push/pop every cycle.
        for (int i = 0; i < 100; i++) cycle(1'b1, DW'(16'h0100 + i), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush with five words held and a push in the same cycle.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(16'h0300 + i), 1'b1, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, DW'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset with three words held.
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h0400 + i), 1'b0, 1'b0);
        #2;
        do_reset(2);

        for (int i = 0; i < 100; i++) begin
            cycle($urandom_range(0, 1) != 0, DW'($urandom),
                  $urandom_range(0, 3) != 0, 1'b0);
        end
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dut_stream_fifo
`default_nettype wire
